// File: rtl/nios_debug_ram_arbiter.sv
// Shares one synchronous debug RAM port between the CPU slave and the JTAG monitor.
// Define NIOS_DEBUG_ARB_AUTOINC_EN to post-increment the JTAG address on each completion.
module nios_debug_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_JTAG, RDATA} state_t;

    state_t            state_q, state_d;
    logic              rd_jtag_q, rd_jtag_d;
    logic              last_jtag_q, last_jtag_d;
    logic              jpend_q, jpend_d;
    logic              jwr_q, jwr_d;
    logic [DATA_W-1:0] jwdata_q, jwdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;

    logic cpu_req;
    logic jdone;
    logic cdone;

    assign cpu_req = cpu_read | cpu_write;
    assign jdone   = (state_q == GRANT_JTAG && jwr_q) ||
                     (state_q == RDATA && rd_jtag_q);
    assign cdone   = (state_q == GRANT_CPU && cpu_write) ||
                     (state_q == RDATA && !rd_jtag_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_jtag_q   <= 1'b0;
            last_jtag_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_jtag_q   <= rd_jtag_d;
            last_jtag_q <= last_jtag_d;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        state_d     = state_q;
        rd_jtag_d   = rd_jtag_q;
        last_jtag_d = last_jtag_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req && (!jpend_q || last_jtag_q)) begin
                    state_d     = GRANT_CPU;
                    last_jtag_d = 1'b0;
                end else if (jpend_q) begin
                    state_d     = GRANT_JTAG;
                    last_jtag_d = 1'b1;
                end
            end
            GRANT_CPU: begin
                rd_jtag_d = 1'b0;
                state_d   = cpu_write ? IDLE : RDATA;
            end
            GRANT_JTAG: begin
                rd_jtag_d = 1'b1;
                state_d   = jwr_q ? IDLE : RDATA;
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = jaddr_q;
        ram_wdata = jwdata_q;
        unique case (state_q)
            GRANT_CPU: begin
                ram_addr  = cpu_address;
                ram_wdata = cpu_writedata;
                ram_we    = cpu_write;
            end
            GRANT_JTAG: ram_we = jwr_q;
            default:    ram_we = 1'b0;
        endcase
        cpu_waitrequest = cpu_req && !cdone;
        cpu_readdata    = ram_rdata;
    end

    // A request in the completing cycle refills the slot being freed.
    always_comb begin
        jpend_d  = jpend_q;
        jwr_d    = jwr_q;
        jwdata_d = jwdata_q;
        jaddr_d  = jaddr_q;
        mon_d    = mon_q;
        rdy_d    = rdy_q;
        err_d    = err_q;
        if (jdone) begin
            jpend_d = 1'b0;
            rdy_d   = 1'b1;
        end
        if (jtag_req) begin
            rdy_d = 1'b0;
            if (!jpend_q || jdone) begin
                jpend_d  = 1'b1;
                jwr_d    = jtag_wr;
                jwdata_d = jtag_wdata;
            end else begin
                err_d = 1'b1;
            end
        end
        if (state_q == RDATA && rd_jtag_q) begin
            mon_d = ram_rdata;
        end
        if (jtag_addr_load) begin
            jaddr_d = jtag_addr;
        end
`ifdef NIOS_DEBUG_ARB_AUTOINC_EN
        else if (jdone) begin
            jaddr_d = jaddr_q + ADDR_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jpend_q  <= 1'b0;
            jwr_q    <= 1'b0;
            jwdata_q <= '0;
            jaddr_q  <= '0;
            mon_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            jpend_q  <= jpend_d;
            jwr_q    <= jwr_d;
            jwdata_q <= jwdata_d;
            jaddr_q  <= jaddr_d;
            mon_q    <= mon_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
        end
    end

    assign MonDReg       = mon_q;
    assign monitor_ready = rdy_q;
    assign monitor_error = err_q;

endmodule
